// File: rtl/l2_request_arbiter.sv
// Round-robin arbiter that hands the single L2 request port to either the
// icache or dcache miss path for the full length of that cache's request.
package l2_request_arbiter_pkg;
  typedef enum logic {LOAD = 1'b0, STORE = 1'b1} memory_operation_e;
endpackage

module l2_request_arbiter
  import l2_request_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dcache_req_valid,
  input  memory_operation_e     dcache_req_type,
  input  logic [ADDR_WIDTH-1:0] dcache_req_address,
  input  logic [XLEN-1:0]       dcache_req_wdata,
  output logic                  dcache_req_fulfilled,
  output logic [XLEN-1:0]       dcache_req_rdata,
  input  logic                  icache_req_valid,
  input  logic [ADDR_WIDTH-1:0] icache_req_address,
  output logic                  icache_req_fulfilled,
  output logic [XLEN-1:0]       icache_req_rdata,
  output logic                  l2_req_valid,
  output memory_operation_e     l2_req_type,
  output logic [ADDR_WIDTH-1:0] l2_req_address,
  output logic [XLEN-1:0]       l2_req_wdata,
  input  logic                  l2_req_fulfilled,
  input  logic [XLEN-1:0]       l2_req_rdata,
  output logic                  protocol_error
);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT_D, ST_GRANT_I} state_e;

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;  // 1 = icache was granted last
  logic   protocol_error_q, protocol_error_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      last_grant_q     <= 1'b1;
      protocol_error_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      last_grant_q     <= last_grant_d;
      protocol_error_q <= protocol_error_d;
    end
  end

  // Owners are never preempted; a release with the other side waiting hands
  // off directly without passing through idle.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (dcache_req_valid && icache_req_valid)
          state_d = last_grant_q ? ST_GRANT_D : ST_GRANT_I;
        else if (dcache_req_valid)
          state_d = ST_GRANT_D;
        else if (icache_req_valid)
          state_d = ST_GRANT_I;
      end
      ST_GRANT_D: if (!dcache_req_valid) state_d = icache_req_valid ? ST_GRANT_I : ST_IDLE;
      ST_GRANT_I: if (!icache_req_valid) state_d = dcache_req_valid ? ST_GRANT_D : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (state_d == ST_GRANT_D) last_grant_d = 1'b0;
    if (state_d == ST_GRANT_I) last_grant_d = 1'b1;
  end

  // Fulfilled is only forwarded while the owner's valid is high, so a pulse
  // landing on a release cycle is treated as stray rather than delivered.
  always_comb begin
    l2_req_valid         = 1'b0;
    l2_req_type          = LOAD;
    l2_req_address       = '0;
    l2_req_wdata         = '0;
    dcache_req_fulfilled = 1'b0;
    icache_req_fulfilled = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_GRANT_D: begin
          l2_req_valid         = dcache_req_valid;
          l2_req_type          = dcache_req_type;
          l2_req_address       = dcache_req_address;
          l2_req_wdata         = dcache_req_wdata;
          dcache_req_fulfilled = dcache_req_valid & l2_req_fulfilled;
        end
        ST_GRANT_I: begin
          l2_req_valid         = icache_req_valid;
          l2_req_address       = icache_req_address;
          icache_req_fulfilled = icache_req_valid & l2_req_fulfilled;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    protocol_error_d = protocol_error_q | (l2_req_fulfilled & ~l2_req_valid);
  end

  assign protocol_error   = protocol_error_q;
  assign dcache_req_rdata = l2_req_rdata;
  assign icache_req_rdata = l2_req_rdata;

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed bench for l2_request_arbiter: grant ownership, round-robin ties,
// handoff, stray fulfilled detection and reset during a burst.
module tb_l2_request_arbiter;
  import l2_request_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int XW = 32;

  logic              clk;
  logic              reset;
  logic              dv;
  memory_operation_e dtype;
  logic [AW-1:0]     daddr;
  logic [XW-1:0]     dwdata;
  logic              dful;
  logic [XW-1:0]     drdata;
  logic              iv;
  logic [AW-1:0]     iaddr;
  logic              iful;
  logic [XW-1:0]     irdata;
  logic              l2v;
  memory_operation_e l2type;
  logic [AW-1:0]     l2addr;
  logic [XW-1:0]     l2wdata;
  logic              l2f;
  logic [XW-1:0]     l2rdata;
  logic              perr;

  int checks = 0;
  int errors = 0;

  l2_request_arbiter #(.ADDR_WIDTH(AW), .XLEN(XW)) dut (
    .clk                  (clk),
    .reset                (reset),
    .dcache_req_valid     (dv),
    .dcache_req_type      (dtype),
    .dcache_req_address   (daddr),
    .dcache_req_wdata     (dwdata),
    .dcache_req_fulfilled (dful),
    .dcache_req_rdata     (drdata),
    .icache_req_valid     (iv),
    .icache_req_address   (iaddr),
    .icache_req_fulfilled (iful),
    .icache_req_rdata     (irdata),
    .l2_req_valid         (l2v),
    .l2_req_type          (l2type),
    .l2_req_address       (l2addr),
    .l2_req_wdata         (l2wdata),
    .l2_req_fulfilled     (l2f),
    .l2_req_rdata         (l2rdata),
    .protocol_error       (perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; dv = 1'b0; dtype = LOAD; daddr = '0; dwdata = '0;
    iv = 1'b0; iaddr = '0; l2f = 1'b0; l2rdata = '0;
    tick(); tick();
    #1;
    checks++; if (l2v !== 1'b0) begin errors++; $display("FAIL reset_l2_valid: got %b want 0", l2v); end
    checks++; if (l2type !== LOAD) begin errors++; $display("FAIL reset_l2_type: got %b want LOAD", l2type); end
    checks++; if (l2addr !== '0 || l2wdata !== '0) begin errors++; $display("FAIL reset_l2_addr_wdata: got %h/%h want 0/0", l2addr, l2wdata); end
    checks++; if (dful !== 1'b0 || iful !== 1'b0) begin errors++; $display("FAIL reset_fulfilled: got d=%b i=%b want 0/0", dful, iful); end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", perr); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_lone_dcache();
    int pulses = 0;
    dv = 1'b1; dtype = LOAD; daddr = 32'h100;
    #1;
    checks++; if (l2v !== 1'b0) begin errors++; $display("FAIL lone_d_cycle0_valid: got %b want 0", l2v); end
    for (int c = 1; c <= 8; c++) begin
      tick();
      daddr   = 32'h100 + 32'(4 * ((c - 1) / 2));
      l2f     = (c % 2 == 0);
      l2rdata = 32'hA000 + 32'(c);
      #1;
      checks++; if (l2v !== 1'b1) begin errors++; $display("FAIL lone_d_valid c%0d: got %b want 1", c, l2v); end
      checks++; if (l2addr !== 32'h100 + 32'(4 * ((c - 1) / 2))) begin errors++; $display("FAIL lone_d_addr c%0d: got %h want %h", c, l2addr, 32'h100 + 32'(4 * ((c - 1) / 2))); end
      checks++; if (dful !== (c % 2 == 0)) begin errors++; $display("FAIL lone_d_dful c%0d: got %b want %b", c, dful, (c % 2 == 0)); end
      checks++; if (iful !== 1'b0) begin errors++; $display("FAIL lone_d_iful c%0d: got %b want 0", c, iful); end
      checks++; if (drdata !== 32'hA000 + 32'(c) || irdata !== 32'hA000 + 32'(c)) begin errors++; $display("FAIL lone_d_rdata c%0d: got %h/%h want %h", c, drdata, irdata, 32'hA000 + 32'(c)); end
      if (dful === 1'b1) pulses++;
    end
    checks++; if (pulses !== 4) begin errors++; $display("FAIL lone_d_pulse_count: got %0d want 4", pulses); end
    tick();
    dv = 1'b0; l2f = 1'b0;
    #1;
    checks++; if (l2v !== 1'b0) begin errors++; $display("FAIL lone_d_release_valid: got %b want 0", l2v); end
    tick();
  endtask

  task automatic test_tie_after_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    dv = 1'b1; iv = 1'b1; dtype = STORE; daddr = 32'h200; dwdata = 32'hDEAD; iaddr = 32'h300;
    #1;
    checks++; if (l2v !== 1'b0) begin errors++; $display("FAIL tie_cycle0_valid: got %b want 0", l2v); end
    tick();
    #1;
    checks++; if (l2v !== 1'b1 || l2addr !== 32'h200) begin errors++; $display("FAIL tie_d_granted: got v=%b addr=%h want 1/200", l2v, l2addr); end
    checks++; if (l2type !== STORE || l2wdata !== 32'hDEAD) begin errors++; $display("FAIL tie_d_type_wdata: got %b/%h want STORE/dead", l2type, l2wdata); end
    tick();
    l2f = 1'b1;
    #1;
    checks++; if (dful !== 1'b1 || iful !== 1'b0) begin errors++; $display("FAIL tie_d_fulfilled: got d=%b i=%b want 1/0", dful, iful); end
    tick();
    l2f = 1'b0; dv = 1'b0;
    #1;
    checks++; if (l2v !== 1'b0) begin errors++; $display("FAIL tie_release_valid: got %b want 0", l2v); end
    tick();
    l2f = 1'b1;
    #1;
    checks++; if (l2v !== 1'b1 || l2addr !== 32'h300) begin errors++; $display("FAIL tie_handoff_i: got v=%b addr=%h want 1/300", l2v, l2addr); end
    checks++; if (l2type !== LOAD || l2wdata !== '0) begin errors++; $display("FAIL tie_i_type_wdata: got %b/%h want LOAD/0", l2type, l2wdata); end
    checks++; if (iful !== 1'b1 || dful !== 1'b0) begin errors++; $display("FAIL tie_i_fulfilled: got i=%b d=%b want 1/0", iful, dful); end
    tick();
    l2f = 1'b0; iv = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    dv = 1'b1; iv = 1'b1; dtype = LOAD;
    tick();
    #1;
    checks++; if (l2v !== 1'b1 || l2addr !== 32'h200) begin errors++; $display("FAIL rr_first_d: got v=%b addr=%h want 1/200", l2v, l2addr); end
    tick();
    dv = 1'b0; iv = 1'b0;
    tick();
    dv = 1'b1; iv = 1'b1;
    #1;
    checks++; if (l2v !== 1'b0) begin errors++; $display("FAIL rr_idle_valid: got %b want 0", l2v); end
    tick();
    #1;
    checks++; if (l2v !== 1'b1 || l2addr !== 32'h300) begin errors++; $display("FAIL rr_second_i: got v=%b addr=%h want 1/300", l2v, l2addr); end
    tick();
    dv = 1'b0; iv = 1'b0;
    tick();
  endtask

  task automatic test_no_preempt();
    dv = 1'b1; iv = 1'b1; dtype = STORE; daddr = 32'h400;
    for (int c = 1; c <= 8; c++) begin
      tick();
      daddr = 32'h400 + 32'(4 * (c - 1));
      dtype = (c >= 5) ? LOAD : STORE;
      l2f   = 1'b1;
      #1;
      checks++; if (l2v !== 1'b1 || l2addr !== 32'h400 + 32'(4 * (c - 1))) begin errors++; $display("FAIL nopre_addr c%0d: got v=%b addr=%h", c, l2v, l2addr); end
      checks++; if (l2type !== ((c >= 5) ? LOAD : STORE)) begin errors++; $display("FAIL nopre_type c%0d: got %b want %b", c, l2type, (c >= 5) ? LOAD : STORE); end
      checks++; if (iful !== 1'b0 || dful !== 1'b1) begin errors++; $display("FAIL nopre_fulfilled c%0d: got i=%b d=%b want 0/1", c, iful, dful); end
    end
    tick();
    dv = 1'b0; l2f = 1'b0;
    #1;
    checks++; if (l2v !== 1'b0) begin errors++; $display("FAIL nopre_release: got %b want 0", l2v); end
    tick();
    #1;
    checks++; if (l2v !== 1'b1 || l2addr !== 32'h300 || l2type !== LOAD) begin errors++; $display("FAIL nopre_i_after: got v=%b addr=%h type=%b", l2v, l2addr, l2type); end
    tick();
    iv = 1'b0;
    tick();
  endtask

  task automatic test_stray_fulfilled();
    #1;
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL stray_before: got %b want 0", perr); end
    l2f = 1'b1;
    #1;
    checks++; if (dful !== 1'b0 || iful !== 1'b0) begin errors++; $display("FAIL stray_forwarded: got d=%b i=%b want 0/0", dful, iful); end
    tick();
    l2f = 1'b0;
    #1;
    checks++; if (perr !== 1'b1) begin errors++; $display("FAIL stray_set: got %b want 1", perr); end
    tick(); tick(); tick();
    checks++; if (perr !== 1'b1) begin errors++; $display("FAIL stray_sticky: got %b want 1", perr); end
  endtask

  task automatic test_reset_mid_burst();
    iv = 1'b1; iaddr = 32'h500;
    tick();
    l2f = 1'b1;
    #1;
    checks++; if (l2v !== 1'b1 || iful !== 1'b1) begin errors++; $display("FAIL rmb_beat0: got v=%b i=%b want 1/1", l2v, iful); end
    tick();
    iaddr = 32'h504;
    tick();
    iaddr = 32'h508; l2f = 1'b0; reset = 1'b1;
    #1;
    checks++; if (l2v !== 1'b0) begin errors++; $display("FAIL rmb_reset_cycle_valid: got %b want 0", l2v); end
    tick();
    reset = 1'b0; dv = 1'b1; daddr = 32'h600; dtype = LOAD;
    #1;
    checks++; if (l2v !== 1'b0) begin errors++; $display("FAIL rmb_after_edge_valid: got %b want 0", l2v); end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL rmb_perr_cleared: got %b want 0", perr); end
    tick();
    #1;
    checks++; if (l2v !== 1'b1 || l2addr !== 32'h600) begin errors++; $display("FAIL rmb_d_wins_tie: got v=%b addr=%h want 1/600", l2v, l2addr); end
    dv = 1'b0; iv = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_lone_dcache();
    test_tie_after_reset();
    test_round_robin();
    test_no_preempt();
    test_stray_fulfilled();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
